// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: reset PC, fetch FSM encodings, the nop
// word and the bundle registered toward ID.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic        in_ds;
    logic        valid;
    logic        adel;
  } id_bundle_t;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_en_flop.sv
// Enable flop with synchronous active-high clear; holds its value when en is low.
module fetch_stage_en_flop #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (en) val_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

  assign q = val_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs one outstanding fetch at a time over the
// req/addr_ok/data_ok bus, and registers the fetched instruction toward ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_stall_i,
  input  logic         if_flush_i,
  input  logic [31:0]  if_flush_pc_i,
  input  logic         id_branch_en_i,
  input  logic [31:0]  id_branch_pc_i,
  output logic         inst_req_o,
  output logic [31:0]  inst_addr_o,
  input  logic         inst_addr_ok_i,
  input  logic         inst_data_ok_i,
  input  logic [31:0]  inst_rdata_i,
  output logic [31:0]  id_pc_o,
  output logic [31:0]  id_inst_o,
  output logic         id_in_delay_slot_o,
  output logic         id_valid_o,
  output logic         id_adel_o,
  output fetch_state_e dbg_state_o
);

  // Handshake: a fetch is accepted in the cycle inst_req_o and inst_addr_ok_i
  // are both high; its word returns in a later cycle with inst_data_ok_i.
  // Only one fetch is ever outstanding, so data_ok needs no tag.

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         discard_q, discard_d;
  logic         pend_br_q, pend_br_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;
  logic         ds_flag_q, ds_flag_d;
  logic [31:0]  hold_inst_q, hold_inst_d;
  logic         hold_adel_q, hold_adel_d;

  logic         misaligned;
  logic         req_raw;
  logic         accepted;
  logic         arrived;
  logic [31:0]  arr_inst;
  logic         arr_adel;
  logic         deliver;
  logic [31:0]  dlv_inst;
  logic         dlv_adel;
  logic         dlv_ds;
  logic         take_branch;
  id_bundle_t   id_bundle_d;
  id_bundle_t   id_bundle_q;
  logic         id_bundle_en;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;
    pend_br_d   = pend_br_q;
    pend_tgt_d  = pend_tgt_q;
    ds_flag_d   = ds_flag_q;
    hold_inst_d = hold_inst_q;
    hold_adel_d = hold_adel_q;
    arrived     = 1'b0;
    arr_inst    = NOP_INST;
    arr_adel    = 1'b0;
    deliver     = 1'b0;
    dlv_inst    = NOP_INST;
    dlv_adel    = 1'b0;
    dlv_ds      = ds_flag_q;
    misaligned  = pc_misaligned(pc_q);
    req_raw     = (state_q == S_REQ) && !misaligned;
    accepted    = req_raw && inst_addr_ok_i;
    take_branch = !if_stall_i && id_branch_en_i;

    if (if_flush_i) begin
      pc_d      = if_flush_pc_i;
      pend_br_d = 1'b0;
      ds_flag_d = 1'b0;
      // A response still owed by the bus must be swallowed when it lands.
      if ((state_q == S_WAIT && !inst_data_ok_i) || accepted) begin
        discard_d = 1'b1;
        state_d   = S_WAIT;
      end else begin
        discard_d = 1'b0;
        state_d   = S_REQ;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (misaligned) begin
            arrived  = 1'b1;
            arr_inst = NOP_INST;
            arr_adel = 1'b1;
          end else if (inst_addr_ok_i) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_data_ok_i) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else begin
              arrived  = 1'b1;
              arr_inst = inst_rdata_i;
            end
          end
        end
        S_HOLD: begin
          if (!if_stall_i) begin
            deliver  = 1'b1;
            dlv_inst = hold_inst_q;
            dlv_adel = hold_adel_q;
            state_d  = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase

      if (arrived) begin
        if (if_stall_i) begin
          hold_inst_d = arr_inst;
          hold_adel_d = arr_adel;
          state_d     = S_HOLD;
        end else begin
          deliver  = 1'b1;
          dlv_inst = arr_inst;
          dlv_adel = arr_adel;
          state_d  = S_REQ;
        end
      end

      // A branch seen alongside a delivery makes that word the delay slot.
      if (deliver) begin
        if (take_branch) begin
          dlv_ds = 1'b1;
          pc_d   = id_branch_pc_i;
        end else begin
          pc_d = pend_br_q ? pend_tgt_q : pc_q + PC_STEP;
        end
        pend_br_d = 1'b0;
        ds_flag_d = 1'b0;
      end else if (take_branch) begin
        pend_br_d  = 1'b1;
        pend_tgt_d = id_branch_pc_i;
        ds_flag_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      discard_q   <= 1'b0;
      pend_br_q   <= 1'b0;
      pend_tgt_q  <= '0;
      ds_flag_q   <= 1'b0;
      hold_inst_q <= '0;
      hold_adel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      pend_br_q   <= pend_br_d;
      pend_tgt_q  <= pend_tgt_d;
      ds_flag_q   <= ds_flag_d;
      hold_inst_q <= hold_inst_d;
      hold_adel_q <= hold_adel_d;
    end
  end

  // Flush zeroes the ID bundle even while stalled; otherwise stall freezes it.
  always_comb begin
    id_bundle_en = if_flush_i || !if_stall_i;
    id_bundle_d  = '0;
    if (deliver) begin
      id_bundle_d.inst  = dlv_inst;
      id_bundle_d.in_ds = dlv_ds;
      id_bundle_d.valid = 1'b1;
      id_bundle_d.adel  = dlv_adel;
    end
  end

  fetch_stage_en_flop #(.W($bits(id_bundle_t))) u_id_bundle (
    .clk (clk),
    .rst (rst),
    .en  (id_bundle_en),
    .d   (id_bundle_d),
    .q   (id_bundle_q)
  );

  fetch_stage_en_flop #(.W(32)) u_id_pc (
    .clk (clk),
    .rst (rst),
    .en  (deliver),
    .d   (pc_q),
    .q   (id_pc_o)
  );

  assign inst_req_o         = req_raw && !rst;
  assign inst_addr_o        = pc_q;
  assign id_inst_o          = id_bundle_q.inst;
  assign id_in_delay_slot_o = id_bundle_q.in_ds;
  assign id_valid_o         = id_bundle_q.valid;
  assign id_adel_o          = id_bundle_q.adel;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage: one record per clock cycle with
// bus/control inputs and the expected request and ID-register outputs.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] R = 32'hBFC0_0000;

  logic         clk;
  logic         rst;
  logic         if_stall_i;
  logic         if_flush_i;
  logic [31:0]  if_flush_pc_i;
  logic         id_branch_en_i;
  logic [31:0]  id_branch_pc_i;
  logic         inst_req_o;
  logic [31:0]  inst_addr_o;
  logic         inst_addr_ok_i;
  logic         inst_data_ok_i;
  logic [31:0]  inst_rdata_i;
  logic [31:0]  id_pc_o;
  logic [31:0]  id_inst_o;
  logic         id_in_delay_slot_o;
  logic         id_valid_o;
  logic         id_adel_o;
  fetch_state_e dbg_state_o;

  int n_checks;
  int n_errors;

  // ctl = {rst, stall, flush, br_en, addr_ok, data_ok}; eb = {req, valid, ds, adel}
  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] fpc;
    logic [31:0] bpc;
    logic [31:0] rdata;
    logic [3:0]  eb;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[28];

  fetch_stage #(.RESET_PC(R)) dut (
    .clk                (clk),
    .rst                (rst),
    .if_stall_i         (if_stall_i),
    .if_flush_i         (if_flush_i),
    .if_flush_pc_i      (if_flush_pc_i),
    .id_branch_en_i     (id_branch_en_i),
    .id_branch_pc_i     (id_branch_pc_i),
    .inst_req_o         (inst_req_o),
    .inst_addr_o        (inst_addr_o),
    .inst_addr_ok_i     (inst_addr_ok_i),
    .inst_data_ok_i     (inst_data_ok_i),
    .inst_rdata_i       (inst_rdata_i),
    .id_pc_o            (id_pc_o),
    .id_inst_o          (id_inst_o),
    .id_in_delay_slot_o (id_in_delay_slot_o),
    .id_valid_o         (id_valid_o),
    .id_adel_o          (id_adel_o),
    .dbg_state_o        (dbg_state_o)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input fetch_state_e exp);
    n_checks++;
    if (dbg_state_o !== exp) begin
      n_errors++;
      $display("FAIL %s: state got %0d expected %0d", name, dbg_state_o, exp);
    end
  endtask

  // driver + checker for one cycle
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    {rst, if_stall_i, if_flush_i, id_branch_en_i, inst_addr_ok_i, inst_data_ok_i} = v.ctl;
    if_flush_pc_i  = v.fpc;
    id_branch_pc_i = v.bpc;
    inst_rdata_i   = v.rdata;
    #1;
    chk32({tag, ".req"},  {31'd0, inst_req_o}, {31'd0, v.eb[3]});
    chk32({tag, ".addr"}, inst_addr_o, v.e_addr);
    @(posedge clk);
    #1;
    chk32({tag, ".valid"}, {31'd0, id_valid_o},         {31'd0, v.eb[2]});
    chk32({tag, ".ds"},    {31'd0, id_in_delay_slot_o}, {31'd0, v.eb[1]});
    chk32({tag, ".adel"},  {31'd0, id_adel_o},          {31'd0, v.eb[0]});
    chk32({tag, ".inst"},  id_inst_o, v.e_inst);
    if (v.eb[2]) chk32({tag, ".pc"}, id_pc_o, v.e_pc);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    if_stall_i = 1'b0;
    if_flush_i = 1'b0;
    if_flush_pc_i = '0;
    id_branch_en_i = 1'b0;
    id_branch_pc_i = '0;
    inst_addr_ok_i = 1'b0;
    inst_data_ok_i = 1'b0;
    inst_rdata_i = '0;

    // basic fetch, branch with delay slot, stall hold, flush in wait/at accept,
    // misaligned flush target, branch coinciding with delivery
    vecs[0]  = '{6'b000010, 32'h0, 32'h0,         32'h0,         4'b1000, R,           32'h0,       32'h0};
    vecs[1]  = '{6'b000001, 32'h0, 32'h0,         32'h2408_0001, 4'b0100, R,           R,           32'h2408_0001};
    vecs[2]  = '{6'b000110, 32'h0, R + 32'h100,   32'h0,         4'b1000, R + 32'h4,   32'h0,       32'h0};
    vecs[3]  = '{6'b000001, 32'h0, 32'h0,         32'hAAAA_0004, 4'b0110, R + 32'h4,   R + 32'h4,   32'hAAAA_0004};
    vecs[4]  = '{6'b000000, 32'h0, 32'h0,         32'h0,         4'b1000, R + 32'h100, 32'h0,       32'h0};
    vecs[5]  = '{6'b000010, 32'h0, 32'h0,         32'h0,         4'b1000, R + 32'h100, 32'h0,       32'h0};
    vecs[6]  = '{6'b000001, 32'h0, 32'h0,         32'hBBBB_0100, 4'b0100, R + 32'h100, R + 32'h100, 32'hBBBB_0100};
    vecs[7]  = '{6'b010010, 32'h0, 32'h0,         32'h0,         4'b1100, R + 32'h104, R + 32'h100, 32'hBBBB_0100};
    vecs[8]  = '{6'b010001, 32'h0, 32'h0,         32'hCCCC_0104, 4'b0100, R + 32'h104, R + 32'h100, 32'hBBBB_0100};
    vecs[9]  = '{6'b010000, 32'h0, 32'h0,         32'h0,         4'b0100, R + 32'h104, R + 32'h100, 32'hBBBB_0100};
    vecs[10] = '{6'b000000, 32'h0, 32'h0,         32'h0,         4'b0100, R + 32'h104, R + 32'h104, 32'hCCCC_0104};
    vecs[11] = '{6'b000000, 32'h0, 32'h0,         32'h0,         4'b1000, R + 32'h108, 32'h0,       32'h0};
    vecs[12] = '{6'b000010, 32'h0, 32'h0,         32'h0,         4'b1000, R + 32'h108, 32'h0,       32'h0};
    vecs[13] = '{6'b001000, R + 32'h380, 32'h0,   32'h0,         4'b0000, R + 32'h108, 32'h0,       32'h0};
    vecs[14] = '{6'b000001, 32'h0, 32'h0,         32'hDEAD_BEEF, 4'b0000, R + 32'h380, 32'h0,       32'h0};
    vecs[15] = '{6'b000010, 32'h0, 32'h0,         32'h0,         4'b1000, R + 32'h380, 32'h0,       32'h0};
    vecs[16] = '{6'b000001, 32'h0, 32'h0,         32'h1111_0380, 4'b0100, R + 32'h380, R + 32'h380, 32'h1111_0380};
    vecs[17] = '{6'b001010, R + 32'h380, 32'h0,   32'h0,         4'b1000, R + 32'h384, 32'h0,       32'h0};
    vecs[18] = '{6'b000001, 32'h0, 32'h0,         32'hDEAD_0384, 4'b0000, R + 32'h380, 32'h0,       32'h0};
    vecs[19] = '{6'b000010, 32'h0, 32'h0,         32'h0,         4'b1000, R + 32'h380, 32'h0,       32'h0};
    vecs[20] = '{6'b000001, 32'h0, 32'h0,         32'h2222_0380, 4'b0100, R + 32'h380, R + 32'h380, 32'h2222_0380};
    vecs[21] = '{6'b001000, R + 32'h381, 32'h0,   32'h0,         4'b1000, R + 32'h384, 32'h0,       32'h0};
    vecs[22] = '{6'b000000, 32'h0, 32'h0,         32'h0,         4'b0101, R + 32'h381, R + 32'h381, 32'h0};
    vecs[23] = '{6'b000000, 32'h0, 32'h0,         32'h0,         4'b0101, R + 32'h385, R + 32'h385, 32'h0};
    vecs[24] = '{6'b001000, R,     32'h0,         32'h0,         4'b0000, R + 32'h389, 32'h0,       32'h0};
    vecs[25] = '{6'b000010, 32'h0, 32'h0,         32'h0,         4'b1000, R,           32'h0,       32'h0};
    vecs[26] = '{6'b000101, 32'h0, R + 32'h200,   32'h3333_0000, 4'b0110, R,           R,           32'h3333_0000};
    vecs[27] = '{6'b000000, 32'h0, 32'h0,         32'h0,         4'b1000, R + 32'h200, 32'h0,       32'h0};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk32("reset.req", {31'd0, inst_req_o}, 32'd0);
    rst = 1'b0;
    #1;
    chk32("reset.id_valid", {31'd0, id_valid_o}, 32'd0);
    chk32("reset.id_pc", id_pc_o, 32'h0);
    chk32("reset.id_inst", id_inst_o, 32'h0);
    chk32("reset.id_ds", {31'd0, id_in_delay_slot_o}, 32'd0);
    chk32("reset.id_adel", {31'd0, id_adel_o}, 32'd0);
    chk32("reset.addr", inst_addr_o, R);
    chk_state("reset.state", S_REQ);

    for (int i = 0; i < 28; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // flush while holding a stalled word: word dropped, refetch from target
    run_vec('{6'b000010, 32'h0, 32'h0, 32'h0,         4'b1000, R + 32'h200, 32'h0, 32'h0}, "hold_a");
    run_vec('{6'b010001, 32'h0, 32'h0, 32'h4444_0200, 4'b0000, R + 32'h200, 32'h0, 32'h0}, "hold_b");
    chk_state("hold_b.state", S_HOLD);
    run_vec('{6'b011000, R + 32'h300, 32'h0, 32'h0,   4'b0000, R + 32'h200, 32'h0, 32'h0}, "hold_c");
    chk_state("hold_c.state", S_REQ);
    run_vec('{6'b000010, 32'h0, 32'h0, 32'h0,         4'b1000, R + 32'h300, 32'h0, 32'h0}, "hold_d");
    run_vec('{6'b000001, 32'h0, 32'h0, 32'h5555_0300, 4'b0100, R + 32'h300, R + 32'h300, 32'h5555_0300}, "hold_e");

    // reset mid-transaction: the late data_ok must be ignored
    run_vec('{6'b000010, 32'h0, 32'h0, 32'h0,         4'b1000, R + 32'h304, 32'h0, 32'h0}, "rmid_a");
    run_vec('{6'b100000, 32'h0, 32'h0, 32'h0,         4'b0000, R + 32'h304, 32'h0, 32'h0}, "rmid_b");
    run_vec('{6'b000001, 32'h0, 32'h0, 32'h6666_0000, 4'b1000, R,           32'h0, 32'h0}, "rmid_c");
    chk_state("rmid_c.state", S_REQ);
    run_vec('{6'b000010, 32'h0, 32'h0, 32'h0,         4'b1000, R,           32'h0, 32'h0}, "rmid_d");
    run_vec('{6'b000001, 32'h0, 32'h0, 32'h7777_0000, 4'b0100, R,           R,     32'h7777_0000}, "rmid_e");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS32 core; sits directly upstream of the decoder.
- Owns the PC and issues instruction fetches over an SRAM-like request/addr_ok/data_ok interface.
- Applies branch redirects from ID after the delay-slot fetch, and exception/eret flush redirects from the controller.
- Delivers registered pc/inst/delay-slot/valid/exception bits to ID, holding them during pipeline stall.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- if_stall_i  in  1  controller stall; ID outputs must hold.
- if_flush_i  in  1  controller flush (exception/eret).
- if_flush_pc_i  in  32  redirect target on flush.
- id_branch_en_i  in  1  branch/jump taken, from decoder.
- id_branch_pc_i  in  32  branch target, from decoder.
- inst_req_o  out  1  fetch request.
- inst_addr_o  out  32  fetch address (= pc).
- inst_addr_ok_i  in  1  request accepted.
- inst_data_ok_i  in  1  read data valid.
- inst_rdata_i  in  32  instruction word.
- id_pc_o  out  32  PC of the instruction delivered to ID.
- id_inst_o  out  32  instruction (0 = nop on bubble).
- id_in_delay_slot_o  out  1  delivered instruction is a delay slot.
- id_valid_o  out  1  delivered instruction is real.
- id_adel_o  out  1  fetch address error (pc[1:0] != 0).

Behaviour:

Reset:
- pc = RESET_PC, state = S_REQ, all pending/discard flags = 0.
- All id_* outputs = 0; inst_req_o = 0 during the reset cycle.

Sequencing:
- S_REQ: inst_req_o = 1, inst_addr_o = pc.
  - addr_ok -> S_WAIT.
  - If pc[1:0] != 0, no request is issued; a synthetic instruction (inst = 0, adel = 1) is treated as arriving this cycle.
- S_WAIT: req = 0. On data_ok:
  - discard = 1: clear discard, go to S_REQ, deliver nothing.
  - Otherwise capture rdata into a hold register. If if_stall_i, go to S_HOLD; else deliver and go to S_REQ.
- S_HOLD: when if_stall_i drops, deliver the held word and go to S_REQ.

Deliver:
- Next-cycle id_pc = pc, id_inst = word, id_valid = 1.
- id_in_delay_slot = ds_flag, id_adel as computed.
- pc <= pend_br ? pend_tgt : pc + 4 (wraps mod 2^32); pend_br and ds_flag clear.

ID output registers:
- if_stall_i = 1: id_* hold.
- Otherwise, with nothing delivered that cycle: id_valid = 0, id_inst = 0, id_in_delay_slot = 0, id_adel = 0 (bubble).
- Minimum steady-state latency: addr_ok cycle -> data_ok cycle -> ID register next edge; back-to-back fetches are not overlapped (one outstanding request).

Branch:
- id_branch_en_i sampled only when !if_stall_i: pend_br <= 1, pend_tgt <= id_branch_pc_i, ds_flag <= 1.
- The next delivered instruction is the delay slot; the fetch after it uses pend_tgt.
- A branch sampled in the same cycle as a delivery marks that delivered instruction as the delay slot and applies the target directly.

Flush (priority over branch, stall and delivery):
- pc <= if_flush_pc_i; pend_br, ds_flag clear.
- id_valid <= 0, id_inst <= 0.
- If a request is outstanding (S_WAIT, or S_REQ with addr_ok this cycle): discard <= 1, state S_WAIT. Otherwise state S_REQ.
- S_HOLD -> S_REQ, held word dropped.

Misc:
- A flush arriving while discard is already set keeps discard = 1; only one response is ever outstanding.
- Reset mid-transaction: a late data_ok after reset is ignored (state S_REQ ignores data_ok).

Decomposition:
- Shared defines header: RESET_PC value, state encodings (S_REQ/S_WAIT/S_HOLD), and the nop encoding.
- Reuse the existing enable-flop primitive for the id_* output registers; no other sub-module.

Test Plan:
- Reset, memory returns 32'h2408_0001 at 0xBFC00000 (addr_ok and data_ok one cycle apart) -> id_pc = 0xBFC00000, id_valid = 1; next fetch address 0xBFC00004.
- With id_pc = 0xBFC00000, pulse id_branch_en_i with target 0xBFC00100 -> 0xBFC00004 delivered with id_in_delay_slot = 1; next inst_addr_o = 0xBFC00100.
- Hold if_stall_i high 3 cycles while data_ok arrives -> id_* unchanged; after release, the held word is delivered once; no refetch.
- Assert if_flush_i (pc 0xBFC00380) during S_WAIT -> the stale data_ok is dropped (id_valid = 0); the next request address is 0xBFC00380.
- Flush in the same cycle as addr_ok -> discard set, stale response dropped, then 0xBFC00380 is fetched.
- Flush to 0xBFC00381 -> no inst_req_o; ID gets id_adel = 1, id_inst = 0, id_pc = 0xBFC00381.
